// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - command codes and wait-FSM states for the register bank
package banco_pkg;

  localparam logic [2:0] CMD_IMM_ULA = 3'b000;
  localparam logic [2:0] CMD_REG_ULA = 3'b001;
  localparam logic [2:0] CMD_LOAD    = 3'b010;
  localparam logic [2:0] CMD_LOADI   = 3'b011;
  localparam logic [2:0] CMD_INPUT   = 3'b100;

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    ESPERA_MEM     = 2'd1,
    ESPERA_ENTRADA = 2'd2
  } estado_t;

endpackage

// File: rtl/banco_controle_espera.sv
// rtl/banco_controle_espera.sv - load/input wait FSM and pending destination address
module banco_controle_espera
  import banco_pkg::*;
#(
  parameter int END_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       controle_registradores,
  input  logic [END_W-1:0] endereco_registrador1,
  input  logic             mem_valido,
  input  logic             dado_valido,
  output logic             ocupado,
  output logic             completa,
  output logic             fonte_mem,
  output logic [END_W-1:0] end_pendente
);

  estado_t estado, proximo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= OCIOSO;
      end_pendente <= '0;
    end else begin
      estado <= proximo;
      if (estado == OCIOSO &&
          (controle_registradores == CMD_LOAD || controle_registradores == CMD_INPUT))
        end_pendente <= endereco_registrador1;
    end
  end

  // completa marks the cycle whose edge retires the pending write
  always_comb begin
    proximo   = estado;
    ocupado   = 1'b0;
    completa  = 1'b0;
    fonte_mem = 1'b0;
    case (estado)
      OCIOSO: begin
        if (controle_registradores == CMD_LOAD)       proximo = ESPERA_MEM;
        else if (controle_registradores == CMD_INPUT) proximo = ESPERA_ENTRADA;
      end
      ESPERA_MEM: begin
        ocupado   = 1'b1;
        fonte_mem = 1'b1;
        if (mem_valido) begin
          completa = 1'b1;
          proximo  = OCIOSO;
        end
      end
      ESPERA_ENTRADA: begin
        ocupado = 1'b1;
        if (dado_valido) begin
          completa = 1'b1;
          proximo  = OCIOSO;
        end
      end
      default: proximo = OCIOSO;
    endcase
  end

endmodule

// File: rtl/banco_registradores_param.sv
// rtl/banco_registradores_param.sv - parameterised register file with write bypass and load/input stall
module banco_registradores_param
  import banco_pkg::*;
#(
  parameter int LARGURA  = 16,
  parameter int NUM_REGS = 32,
  parameter int END_W    = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         controle_registradores,
  input  logic [END_W-1:0]   endereco_registrador1,
  input  logic [END_W-1:0]   endereco_registrador2,
  input  logic [END_W-1:0]   endereco_registrador3,
  input  logic [LARGURA-1:0] ula,
  input  logic [LARGURA-1:0] valor,
  input  logic [LARGURA-1:0] registrador_memoria,
  input  logic [LARGURA-1:0] dado,
  input  logic               mem_valido,
  input  logic               dado_valido,
  output logic [LARGURA-1:0] valor1,
  output logic [LARGURA-1:0] valor2,
  output logic [LARGURA-1:0] store,
  output logic               ocupado
);

  logic [LARGURA-1:0] regs [NUM_REGS];
  logic               completa, fonte_mem;
  logic [END_W-1:0]   end_pendente;
  logic               escreve, escreve_efetivo;
  logic [END_W-1:0]   end_escrita;
  logic [LARGURA-1:0] dado_escrita;

  banco_controle_espera #(.END_W(END_W)) u_controle (
    .clk                    (clk),
    .rst                    (rst),
    .controle_registradores (controle_registradores),
    .endereco_registrador1  (endereco_registrador1),
    .mem_valido             (mem_valido),
    .dado_valido            (dado_valido),
    .ocupado                (ocupado),
    .completa               (completa),
    .fonte_mem              (fonte_mem),
    .end_pendente           (end_pendente)
  );

  // While stalled, only the pending completion may write; commands are ignored
  always_comb begin
    escreve      = 1'b0;
    end_escrita  = endereco_registrador1;
    dado_escrita = ula;
    if (ocupado) begin
      end_escrita  = end_pendente;
      dado_escrita = fonte_mem ? registrador_memoria : dado;
      escreve      = completa;
    end else begin
      case (controle_registradores)
        CMD_IMM_ULA, CMD_REG_ULA: escreve = 1'b1;
        CMD_LOADI: begin
          escreve      = 1'b1;
          dado_escrita = valor;
        end
        default: escreve = 1'b0;
      endcase
    end
  end

  assign escreve_efetivo = escreve && (end_escrita != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (escreve_efetivo) begin
      regs[end_escrita] <= dado_escrita;
    end
  end

  function automatic logic [LARGURA-1:0] ler(input logic [END_W-1:0] a);
    if (a == '0)                                  return '0;
    else if (escreve_efetivo && end_escrita == a) return dado_escrita;
    else                                          return regs[a];
  endfunction

  assign valor1 = ler(endereco_registrador2);
  assign valor2 = ler(endereco_registrador3);
  assign store  = ler(endereco_registrador1);

endmodule

// File: tb/tb_banco_registradores_param.sv
// tb/tb_banco_registradores_param.sv - self-checking bench with reference model for the register bank
module tb_banco_registradores_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cmd = 3'b111;
  logic [4:0]  a1 = '0, a2 = '0, a3 = '0;
  logic [15:0] ula = '0, valor = '0, rmem = '0, dado = '0;
  logic        mv = 1'b0, dv = 1'b0;
  logic [15:0] v1, v2, st;
  logic        oc;

  logic [2:0]  b_cmd = 3'b111;
  logic [2:0]  b_a1 = '0, b_a2 = '0, b_a3 = '0;
  logic [31:0] b_valor = '0;
  logic [31:0] b_v1, b_v2, b_st;
  logic        b_oc;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [32];
  int          m_busy;   // 0 idle, 1 waiting memory, 2 waiting input
  int          m_pend;

  always #5 clk = ~clk;

  banco_registradores_param dut (
    .clk(clk), .rst(rst), .controle_registradores(cmd),
    .endereco_registrador1(a1), .endereco_registrador2(a2), .endereco_registrador3(a3),
    .ula(ula), .valor(valor), .registrador_memoria(rmem), .dado(dado),
    .mem_valido(mv), .dado_valido(dv),
    .valor1(v1), .valor2(v2), .store(st), .ocupado(oc)
  );

  banco_registradores_param #(.LARGURA(32), .NUM_REGS(8)) dut_b (
    .clk(clk), .rst(rst), .controle_registradores(b_cmd),
    .endereco_registrador1(b_a1), .endereco_registrador2(b_a2), .endereco_registrador3(b_a3),
    .ula(32'h0), .valor(b_valor), .registrador_memoria(32'h0), .dado(32'h0),
    .mem_valido(1'b0), .dado_valido(1'b0),
    .valor1(b_v1), .valor2(b_v2), .store(b_st), .ocupado(b_oc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = 0;
    m_pend = 0;
  endtask

  // Which register (if any) the coming edge writes, from the architectural rules
  task automatic model_write(output bit we, output int wa, output logic [15:0] wd);
    we = 0; wa = 0; wd = '0;
    if (m_busy == 1 && mv)      begin we = 1; wa = m_pend; wd = rmem; end
    else if (m_busy == 2 && dv) begin we = 1; wa = m_pend; wd = dado; end
    else if (m_busy == 0 && (cmd == 3'd0 || cmd == 3'd1)) begin we = 1; wa = a1; wd = ula; end
    else if (m_busy == 0 && cmd == 3'd3) begin we = 1; wa = a1; wd = valor; end
  endtask

  function automatic logic [15:0] exp_rd(input int a, input bit we, input int wa, input logic [15:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic ciclo(input string tag);
    bit we; int wa; logic [15:0] wd;
    #2;
    model_write(we, wa, wd);
    chk({tag, ".valor1"}, {16'h0, v1}, {16'h0, exp_rd(a2, we, wa, wd)});
    chk({tag, ".valor2"}, {16'h0, v2}, {16'h0, exp_rd(a3, we, wa, wd)});
    chk({tag, ".store"},  {16'h0, st}, {16'h0, exp_rd(a1, we, wa, wd)});
    chk({tag, ".ocupado"}, {31'h0, oc}, {31'h0, (m_busy != 0)});
    @(posedge clk);
    if (we && wa != 0) m_regs[wa] = wd;
    if (m_busy == 0) begin
      if (cmd == 3'd2)      begin m_busy = 1; m_pend = a1; end
      else if (cmd == 3'd4) begin m_busy = 2; m_pend = a1; end
    end else if ((m_busy == 1 && mv) || (m_busy == 2 && dv)) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_clear();
    chk({tag, ".rst_ocupado"}, {31'h0, oc}, 32'h0);
    chk({tag, ".rst_valor1"}, {16'h0, v1}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    cmd = 3'b111; mv = 1'b0; dv = 1'b0;
  endtask

  int busy_cycles;

  initial begin
    model_clear();
    #1;
    // Test 1: loadi then read back
    do_reset("t1");
    cmd = 3'd3; a1 = 5'd5; valor = 16'h1234; a2 = 5'd0; a3 = 5'd0;
    ciclo("t1.wr");
    idle_inputs(); a2 = 5'd5;
    ciclo("t1.rd");
    chk("t1.reg5", {16'h0, v1}, 32'h1234);

    // Test 2: load with 3-cycle memory latency, stray loadi ignored
    cmd = 3'd2; a1 = 5'd7;
    ciclo("t2.issue");
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      cmd = 3'd3; a1 = 5'd7; valor = 16'h9999; mv = 1'b0;
      if (oc) busy_cycles++;
      ciclo("t2.wait");
    end
    idle_inputs(); mv = 1'b1; rmem = 16'hBEEF; a1 = 5'd1;
    if (oc) busy_cycles++;
    ciclo("t2.done");
    chk("t2.busy_cycles", busy_cycles, 32'd4);
    idle_inputs(); a2 = 5'd7;
    ciclo("t2.rd");
    chk("t2.reg7", {16'h0, v1}, 32'hBEEF);

    // Test 3: same-cycle bypass
    cmd = 3'd1; a1 = 5'd3; ula = 16'h00AA; a2 = 5'd3;
    #2;
    chk("t3.bypass", {16'h0, v1}, 32'h00AA);
    #(-0);
    ciclo("t3.wr");

    // Test 4: writes to register 0 discarded; input to r0 still handshakes
    cmd = 3'd3; a1 = 5'd0; valor = 16'hFFFF; a2 = 5'd0;
    ciclo("t4.wr0");
    cmd = 3'd4; a1 = 5'd0;
    ciclo("t4.in0");
    idle_inputs(); dv = 1'b1; dado = 16'h4321;
    ciclo("t4.dv");
    idle_inputs();
    ciclo("t4.after");
    chk("t4.reg0", {16'h0, v1}, 32'h0);
    chk("t4.ocupado", {31'h0, oc}, 32'h0);

    // Test 5: reset mid-wait abandons the input
    cmd = 3'd4; a1 = 5'd9;
    ciclo("t5.issue");
    idle_inputs();
    ciclo("t5.wait");
    do_reset("t5");
    dv = 1'b1; dado = 16'h5555; a2 = 5'd9;
    ciclo("t5.stray");
    idle_inputs();
    ciclo("t5.rd");
    chk("t5.reg9", {16'h0, v1}, 32'h0);

    // Test 6: 32-bit, 8-register instance
    b_cmd = 3'd3; b_a1 = 3'd7; b_valor = 32'hDEADBEEF; b_a2 = 3'd7;
    #2;
    chk("t6.bypass", b_v1, 32'hDEADBEEF);
    @(posedge clk); #1;
    b_cmd = 3'b111; b_a3 = 3'd7;
    #2;
    chk("t6.valor1", b_v1, 32'hDEADBEEF);
    chk("t6.valor2", b_v2, 32'hDEADBEEF);
    chk("t6.store",  b_st, 32'hDEADBEEF);
    chk("t6.ocupado", {31'h0, b_oc}, 32'h0);
    @(posedge clk); #1;

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 96) do_reset("rnd");
      cmd   = 3'($urandom_range(0, 7));
      a1    = 5'($urandom); a2 = 5'($urandom); a3 = 5'($urandom);
      ula   = 16'($urandom); valor = 16'($urandom);
      rmem  = 16'($urandom); dado  = 16'($urandom);
      mv    = ($urandom_range(0, 3) == 0);
      dv    = ($urandom_range(0, 3) == 0);
      ciclo("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
